// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register outstanding-write counters that gate
// instruction issue on RAW hazards and on counter overflow (WAW depth).
module reg_scoreboard #(
  parameter int CNT_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iss_valid,
  input  logic [3:0]  iss_src1,
  input  logic [3:0]  iss_src2,
  input  logic        iss_use1,
  input  logic        iss_use2,
  input  logic [3:0]  iss_dst,
  input  logic        iss_we,
  input  logic        wb_valid,
  input  logic [3:0]  wb_reg,
  input  logic        flush,
  output logic        iss_ready,
  output logic [15:0] pending,
  output logic [15:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt [16];
  logic             raw_hazard;
  logic             waw_ovf;
  logic             issue_fire;
  logic             retire_fire;
  logic             stall;

  // Saturating increment for the stall counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Pending bits decode straight from the counter registers; R0 never counts.
  always_comb begin
    pending = '0;
    for (int r = 1; r < 16; r++) begin
      pending[r] = (cnt[r] != '0);
    end
  end

  // Issue decision uses only pre-edge state and issue-side inputs, so a
  // same-cycle writeback cannot release a waiting reader.
  always_comb begin
    raw_hazard  = (iss_use1 & pending[iss_src1]) | (iss_use2 & pending[iss_src2]);
    waw_ovf     = iss_we & (iss_dst != 4'd0) & (cnt[iss_dst] == CNT_MAX);
    iss_ready   = iss_valid & ~rst & ~flush & ~raw_hazard & ~waw_ovf;
    issue_fire  = iss_ready & iss_we & (iss_dst != 4'd0);
    retire_fire = wb_valid & (wb_reg != 4'd0) & (cnt[wb_reg] != '0);
    stall       = iss_valid & ~iss_ready & ~flush;
  end

  // Counter update: reset beats flush beats issue/retire; a same-register
  // issue and retire in one cycle cancel out.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int r = 0; r < 16; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      cnt[0] <= '0;
      for (int r = 1; r < 16; r++) begin
        if (issue_fire && (iss_dst == 4'(r)) && !(retire_fire && (wb_reg == 4'(r)))) begin
          cnt[r] <= cnt[r] + 1'b1;
        end else if (retire_fire && (wb_reg == 4'(r)) && !(issue_fire && (iss_dst == 4'(r)))) begin
          cnt[r] <= cnt[r] - 1'b1;
        end
      end
    end
  end

  // Stall cycle counter; flush cycles are excluded and the count saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall) begin
      stall_cnt <= sat_inc16(stall_cnt);
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed, table-driven bench for reg_scoreboard (CNT_W = 2).
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        iss_valid;
  logic [3:0]  iss_src1;
  logic [3:0]  iss_src2;
  logic        iss_use1;
  logic        iss_use2;
  logic [3:0]  iss_dst;
  logic        iss_we;
  logic        wb_valid;
  logic [3:0]  wb_reg;
  logic        flush;
  logic        iss_ready;
  logic [15:0] pending;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_scoreboard #(.CNT_W(2)) dut (
    .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_src1(iss_src1),
    .iss_src2(iss_src2), .iss_use1(iss_use1), .iss_use2(iss_use2),
    .iss_dst(iss_dst), .iss_we(iss_we), .wb_valid(wb_valid), .wb_reg(wb_reg),
    .flush(flush), .iss_ready(iss_ready), .pending(pending), .stall_cnt(stall_cnt)
  );

  typedef struct packed {
    logic        rst;
    logic        v;
    logic [3:0]  s1;
    logic        u1;
    logic [3:0]  s2;
    logic        u2;
    logic [3:0]  d;
    logic        we;
    logic        wbv;
    logic [3:0]  wbr;
    logic        fl;
    logic        rdy;
    logic [15:0] pend;
    logic [15:0] stall;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic v, input logic [3:0] s1,
                              input logic u1, input logic [3:0] s2, input logic u2,
                              input logic [3:0] d, input logic we, input logic wbv,
                              input logic [3:0] wbr, input logic fl, input logic rdy,
                              input logic [15:0] pend, input logic [15:0] stall);
    vec_t t;
    t.rst = r; t.v = v; t.s1 = s1; t.u1 = u1; t.s2 = s2; t.u2 = u2; t.d = d;
    t.we = we; t.wbv = wbv; t.wbr = wbr; t.fl = fl; t.rdy = rdy;
    t.pend = pend; t.stall = stall;
    return t;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    rst = t.rst; iss_valid = t.v; iss_src1 = t.s1; iss_use1 = t.u1;
    iss_src2 = t.s2; iss_use2 = t.u2; iss_dst = t.d; iss_we = t.we;
    wb_valid = t.wbv; wb_reg = t.wbr; flush = t.fl;
  endtask

  // Drive one vector mid-cycle, check ready before the edge and state after it.
  task automatic apply(input vec_t t, input int idx);
    @(negedge clk);
    drive(t);
    #1;
    chk($sformatf("ready[%0d]", idx), {15'd0, iss_ready}, {15'd0, t.rdy});
    @(posedge clk);
    #1;
    chk($sformatf("pending[%0d]", idx), pending, t.pend);
    chk($sformatf("stall_cnt[%0d]", idx), stall_cnt, t.stall);
  endtask

  vec_t tbl [26];

  initial begin
    drive(mk(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
    //            rst v  s1 u1 s2 u2 d  we wbv wbr fl rdy pend       stall
    tbl[0]  = mk(1, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 16'h0000, 16'd0);
    tbl[1]  = mk(0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 1, 16'h0008, 16'd0);
    tbl[2]  = mk(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0008, 16'd1);
    tbl[3]  = mk(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0008, 16'd2);
    tbl[4]  = mk(0, 1, 3, 1, 0, 0, 0, 0, 1, 3, 0, 0, 16'h0000, 16'd3);
    tbl[5]  = mk(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'd3);
    tbl[6]  = mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 16'h0000, 16'd3);
    tbl[7]  = mk(0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 16'h0000, 16'd3);
    tbl[8]  = mk(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 1, 16'h0020, 16'd3);
    tbl[9]  = mk(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 1, 16'h0020, 16'd3);
    tbl[10] = mk(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 1, 16'h0020, 16'd3);
    tbl[11] = mk(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 16'h0020, 16'd4);
    tbl[12] = mk(0, 1, 0, 0, 0, 0, 5, 1, 1, 5, 0, 0, 16'h0020, 16'd5);
    tbl[13] = mk(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 1, 16'h0020, 16'd5);
    tbl[14] = mk(0, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 16'h0020, 16'd6);
    tbl[15] = mk(0, 1, 0, 1, 5, 0, 0, 0, 0, 0, 0, 1, 16'h0020, 16'd6);
    tbl[16] = mk(0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 1, 16'h00A0, 16'd6);
    tbl[17] = mk(0, 1, 0, 0, 0, 0, 7, 1, 1, 7, 0, 1, 16'h00A0, 16'd6);
    tbl[18] = mk(0, 1, 0, 0, 0, 0, 4, 1, 1, 5, 0, 1, 16'h00B0, 16'd6);
    tbl[19] = mk(0, 1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 1, 16'h00F0, 16'd6);
    tbl[20] = mk(0, 1, 0, 0, 0, 0, 3, 1, 1, 5, 1, 0, 16'h0000, 16'd6);
    tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 16'h0000, 16'd6);
    tbl[22] = mk(0, 1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 1, 16'h0010, 16'd6);
    tbl[23] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 16'h0000, 16'd6);
    tbl[24] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 16'h0000, 16'd6);
    tbl[25] = mk(0, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'd6);

    repeat (2) @(posedge clk);
    for (int i = 0; i < 26; i++) begin
      apply(tbl[i], i);
    end

    // Build stall_cnt up to 37 behind a pending R9, then reset mid-operation.
    apply(mk(0, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 1, 16'h0200, 16'd6), 100);
    @(negedge clk);
    drive(mk(0, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (31) @(posedge clk);
    #1;
    chk("stall_37", stall_cnt, 16'd37);
    chk("ready_stalled_r9", {15'd0, iss_ready}, 16'd0);
    apply(mk(1, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'd0), 101);

    // Saturation: one producer, then a long stall on its consumer.
    apply(mk(0, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 1, 16'h0200, 16'd0), 102);
    @(negedge clk);
    drive(mk(0, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (65534) @(posedge clk);
    #1;
    chk("stall_fffe", stall_cnt, 16'hFFFE);
    @(posedge clk);
    #1;
    chk("stall_ffff", stall_cnt, 16'hFFFF);
    repeat (5) @(posedge clk);
    #1;
    chk("stall_sat", stall_cnt, 16'hFFFF);
    chk("pending_r9_held", pending, 16'h0200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 Parameter: CNT_W, default 2, width of each register's outstanding-write counter; maximum count is 2^CNT_W-1.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 iss_valid  input  1  decode holds an instruction requesting issue.
REQ-005 iss_src1  input  4  first source register ID; matches the register-file SrcReg1.
REQ-006 iss_src2  input  4  second source register ID; matches the register-file SrcReg2.
REQ-007 iss_use1 / iss_use2  input  1 each  instruction actually reads src1 / src2.
REQ-008 iss_dst  input  4  destination register ID.
REQ-009 iss_we  input  1  instruction will write iss_dst.
REQ-010 wb_valid  input  1  writeback retiring a write this cycle; matches register-file WriteReg.
REQ-011 wb_reg  input  4  register being written back; matches register-file DstReg.
REQ-012 flush  input  1  pipeline squash; discards all outstanding writes.
REQ-013 iss_ready  output  1  issue accepted this cycle; combinational.
REQ-014 pending  output  16  bit r = 1 when register r has a nonzero counter; registered state.
REQ-015 stall_cnt  output  16  saturating count of cycles in which iss_valid=1 and iss_ready=0.

Function
REQ-016 The block SHALL keep one CNT_W-bit counter per register, cnt[r]; pending[r] = (cnt[r] != 0).
REQ-017 Register 0 SHALL be hardwired zero: cnt[0] never increments and src/dst ID 0 never causes a stall.
REQ-018 RAW hazard = (iss_use1 & pending[iss_src1]) | (iss_use2 & pending[iss_src2]), using pre-edge state.
REQ-019 WAW overflow = iss_we & (iss_dst != 0) & (cnt[iss_dst] == max).
REQ-020 iss_ready SHALL be iss_valid & ~flush & ~RAW hazard & ~WAW overflow.
REQ-021 An issue fires when iss_ready=1 and iss_we=1 and iss_dst!=0; it increments cnt[iss_dst] at the next edge.
REQ-022 A retire fires when wb_valid=1 and wb_reg!=0 and cnt[wb_reg]!=0; it decrements cnt[wb_reg] at the next edge.
REQ-023 wb_valid targeting a register with cnt=0 SHALL be ignored and SHALL NOT cause underflow.
REQ-024 If issue and retire target the same register in one cycle, that counter SHALL be unchanged.
REQ-025 If issue and retire target different registers in one cycle, both updates SHALL apply.
REQ-026 A same-cycle writeback SHALL NOT release a source: a stalled reader sees pending clear one cycle after the retire edge.
REQ-027 Latency: a dependent instruction issues no earlier than the cycle after its producer's retire edge.
REQ-028 flush=1 SHALL clear all counters at the next edge, overriding any same-cycle issue or retire; iss_ready=0 during flush.
REQ-029 stall_cnt SHALL increment by 1 per stall cycle and saturate at 16'hFFFF; flush cycles are not counted.
REQ-030 Outputs SHALL have no combinational path from wb_* to iss_ready.

Reset
REQ-031 rst=1 at an edge SHALL set all cnt[r]=0, pending=16'h0000, and stall_cnt=0; rst SHALL take priority over flush, issue, and retire.
REQ-032 While rst=1, iss_ready SHALL be 0.
REQ-033 Reset asserted mid-operation SHALL discard all outstanding writes without requiring any writeback.

Verification
REQ-034 Scenario: after reset, issue dst=R3 with we=1, then next cycle src1=R3 with use1=1 -> iss_ready=0, pending=16'h0008, stall_cnt increments each cycle; wb R3 -> iss_ready=1 one cycle after the retire edge.
REQ-035 Scenario: issue dst=R0 with we=1, then src1=R0 -> pending stays 16'h0000 and iss_ready=1.
REQ-036 Scenario (CNT_W=2): issue to R5 three times -> cnt[R5]=3; fourth issue to R5 -> iss_ready=0; one wb R5 -> the fourth issue is accepted the following cycle.
REQ-037 Scenario: same cycle issue dst=R7 and wb R7 with cnt[R7]=1 -> cnt[R7] stays 1, pending[7]=1.
REQ-038 Scenario: pending=16'h00F0 with flush=1 and simultaneous iss_valid -> iss_ready=0 and pending=16'h0000 next cycle; wb to R4 with cnt=0 -> no change.
REQ-039 Scenario: drive rst=1 with pending nonzero and stall_cnt=37 -> pending=0 and stall_cnt=0 next cycle; stall_cnt driven to 16'hFFFF stays at 16'hFFFF while stalled.
